riscv_core: RTL and testbench

- Single-cycle RV32I integer core: fetches one instruction per clock from a combinational instruction memory, executes it, and retires it on the next rising clk edge.
- Talks to a word-wide data memory: combinational read, write at the clock edge.
- Top-level compute block between the InstructionMemory and DataMemory models in the CPU subsystem.

---
 rtl/riscv_pkg.sv | 103 ++++++++++
 rtl/riscv_core_pc.sv | 19 +
 rtl/riscv_core.sv | 131 +++++++++++++
 tb/tb_riscv_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct fields, ALU/immediate enums, decode
// control word, and the pure combinational helpers used by the core datapath.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_WORD = 3'd2;
  localparam logic [2:0] F3_JALR = 3'd0;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic     rd_we;
    logic     is_load;
    logic     is_store;
    logic     is_branch;
    logic     is_jal;
    logic     is_jalr;
    logic     a_pc;
    logic     a_zero;
    logic     b_imm;
    alu_op_e  alu_op;
    imm_fmt_e imm_fmt;
  } ctrl_t;

  function automatic logic [31:0] imm_gen(imm_fmt_e fmt, logic [31:7] ins);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; the caller only raises it where the encoding allows
  function automatic alu_op_e alu_sel(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_core_pc.sv
// Program counter register; the register is named pc so it can be probed or
// forced hierarchically, and a forced value becomes the next fetch address.
module riscv_core_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc_i;
  end

  assign pc_o = pc;
endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I core: decode, register file, ALU and next-PC logic.
// Every instruction retires on the rising edge after it is presented.
module riscv_core
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] instr_addr,
  output logic [31:0] data_addr,
  output logic        should_write_mem,
  output logic        should_read_mem,
  output logic [31:0] mem_write_data
);
  logic [31:0] pc_cur, next_pc, pc_plus4;
  logic [31:0] rf_q [32];
  logic [31:0] rs1_val, rs2_val, imm, op_a, op_b, alu_res, wb_val;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  opc, f7;
  ctrl_t       ctrl;
  logic        br_cond, taken;

  riscv_core_pc #(.RESET_PC(RESET_PC)) pc (
    .clk       (clk),
    .rst_n     (reset),
    .next_pc_i (next_pc),
    .pc_o      (pc_cur)
  );

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  // Anything not matched (including byte/half memory ops and SYSTEM/FENCE)
  // leaves ctrl all-zero, which is a clean NOP.
  always_comb begin
    ctrl = '0;
    case (opc)
      OPC_LUI:   begin ctrl.rd_we = 1'b1; ctrl.a_zero = 1'b1; ctrl.b_imm = 1'b1; ctrl.imm_fmt = IMM_U; end
      OPC_AUIPC: begin ctrl.rd_we = 1'b1; ctrl.a_pc = 1'b1; ctrl.b_imm = 1'b1; ctrl.imm_fmt = IMM_U; end
      OPC_JAL:   begin ctrl.rd_we = 1'b1; ctrl.is_jal = 1'b1; ctrl.imm_fmt = IMM_J; end
      OPC_JALR:
        if (f3 == F3_JALR) begin
          ctrl.rd_we = 1'b1; ctrl.is_jalr = 1'b1; ctrl.b_imm = 1'b1;
        end
      OPC_BRANCH:
        if (f3 != 3'd2 && f3 != 3'd3) begin
          ctrl.is_branch = 1'b1; ctrl.imm_fmt = IMM_B;
        end
      OPC_LOAD:
        if (f3 == F3_WORD) begin
          ctrl.rd_we = 1'b1; ctrl.is_load = 1'b1; ctrl.b_imm = 1'b1;
        end
      OPC_STORE:
        if (f3 == F3_WORD) begin
          ctrl.is_store = 1'b1; ctrl.b_imm = 1'b1; ctrl.imm_fmt = IMM_S;
        end
      OPC_OP_IMM:
        if ((f3 == F3_SLL && f7 == F7_BASE) ||
            (f3 == F3_SR && (f7 == F7_BASE || f7 == F7_ALT)) ||
            (f3 != F3_SLL && f3 != F3_SR)) begin
          ctrl.rd_we = 1'b1; ctrl.b_imm = 1'b1;
          ctrl.alu_op = alu_sel(f3, f3 == F3_SR && f7[5]);
        end
      OPC_OP:
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
          ctrl.rd_we = 1'b1;
          ctrl.alu_op = alu_sel(f3, f7[5]);
        end
      default: ;
    endcase
  end

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign imm     = imm_gen(ctrl.imm_fmt, instr[31:7]);
  assign op_a    = ctrl.a_zero ? 32'd0 : (ctrl.a_pc ? pc_cur : rs1_val);
  assign op_b    = ctrl.b_imm ? imm : rs2_val;
  assign alu_res = alu_exec(ctrl.alu_op, op_a, op_b);

  always_comb begin
    br_cond = 1'b0;
    case (f3)
      F3_BEQ:  br_cond = (rs1_val == rs2_val);
      F3_BNE:  br_cond = (rs1_val != rs2_val);
      F3_BLT:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_cond = (rs1_val <  rs2_val);
      F3_BGEU: br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken    = ctrl.is_branch & br_cond;
  assign pc_plus4 = pc_cur + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.is_jalr)              next_pc = {alu_res[31:1], 1'b0};
    else if (ctrl.is_jal || taken) next_pc = pc_cur + imm;
  end

  always_comb begin
    wb_val = alu_res;
    if (ctrl.is_jal || ctrl.is_jalr) wb_val = pc_plus4;
    else if (ctrl.is_load)           wb_val = mem_read_data;
  end

  // x0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (ctrl.rd_we && rd != 5'd0) begin
      rf_q[rd] <= wb_val;
    end
  end

  assign instr_addr       = pc_cur;
  assign should_write_mem = reset & ctrl.is_store;
  assign should_read_mem  = reset & ctrl.is_load;
  assign data_addr        = (ctrl.is_load || ctrl.is_store) ? alu_res : 32'd0;
  assign mem_write_data   = ctrl.is_store ? rs2_val : 32'd0;

endmodule

// File: tb/tb_riscv_core.sv
// Scoreboarded bench: an instruction-level reference model predicts the port
// activity of every cycle; a negedge monitor compares it against the core.
module tb_riscv_core;
  localparam logic [6:0] O_OPI = 7'h13, O_OP = 7'h33, O_LD = 7'h03, O_ST = 7'h23;
  localparam logic [6:0] O_BR = 7'h63, O_JAL = 7'h6F, O_JALR = 7'h67, O_LUI = 7'h37, O_AUI = 7'h17;

  typedef struct packed {
    logic [31:0] pc;
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr, mem_read_data, instr_addr, data_addr, mem_write_data;
  logic        should_write_mem, should_read_mem;

  bit   [31:0] imem [256];
  bit   [31:0] dmem [128];
  bit   [31:0] m_mem [128];
  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  riscv_core uut (
    .clk              (clk),
    .reset            (reset),
    .instr            (instr),
    .mem_read_data    (mem_read_data),
    .instr_addr       (instr_addr),
    .data_addr        (data_addr),
    .should_write_mem (should_write_mem),
    .should_read_mem  (should_read_mem),
    .mem_write_data   (mem_write_data)
  );

  always #5 clk = ~clk;

  assign instr         = imem[instr_addr[9:2]];
  assign mem_read_data = dmem[data_addr[8:2]];

  always @(posedge clk) if (should_write_mem) dmem[data_addr[8:2]] <= mem_write_data;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      cyc_no++;
      if ({instr_addr, should_write_mem, should_read_mem, data_addr, mem_write_data} !== e) begin
        errors++;
        $display("FAIL cycle%0d: got pc=%h w=%b r=%b addr=%h wd=%h want pc=%h w=%b r=%b addr=%h wd=%h",
                 cyc_no, instr_addr, should_write_mem, should_read_mem, data_addr, mem_write_data,
                 e.pc, e.w, e.r, e.a, e.d);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], O_ST};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], O_BR};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, O_JAL};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, O_OP};
  endfunction

  function automatic logic [31:0] ref_alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Executes the instruction at m_pc: returns this cycle's port activity and
  // commits the architectural effect.
  task automatic model_step(output exp_t e);
    logic [31:0] in, a, b, iI, iS, iB, iJ, npc, wv, ad;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wr, tk;
    in = imem[m_pc[9:2]];
    f3 = in[14:12]; f7 = in[31:25];
    a  = m_x[in[19:15]]; b = m_x[in[24:20]];
    iI = {{20{in[31]}}, in[31:20]};
    iS = {{20{in[31]}}, in[31:25], in[11:7]};
    iB = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    iJ = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
    e = '0; e.pc = m_pc;
    npc = m_pc + 4; wr = 1'b0; wv = 32'd0; tk = 1'b0;
    case (in[6:0])
      O_LUI: begin wr = 1'b1; wv = {in[31:12], 12'b0}; end
      O_AUI: begin wr = 1'b1; wv = m_pc + {in[31:12], 12'b0}; end
      O_JAL: begin wr = 1'b1; wv = m_pc + 4; npc = m_pc + iJ; end
      O_JALR: if (f3 == 3'd0) begin wr = 1'b1; wv = m_pc + 4; npc = (a + iI) & ~32'd1; end
      O_BR: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = $signed(a) <  $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a <  b;
          3'd7: tk = a >= b;
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + iB;
      end
      O_LD: if (f3 == 3'd2) begin
        ad = a + iI; e.r = 1'b1; e.a = ad; wr = 1'b1; wv = m_mem[ad[8:2]];
      end
      O_ST: if (f3 == 3'd2) begin
        ad = a + iS; e.w = 1'b1; e.a = ad; e.d = b; m_mem[ad[8:2]] = b;
      end
      O_OPI: if ((f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1) begin
        wr = 1'b1; wv = ref_alu(f3, f3 == 3'd5 && f7 == 7'h20, a, iI);
      end
      O_OP: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        wr = 1'b1; wv = ref_alu(f3, f7 == 7'h20, a, b);
      end
      default: ;
    endcase
    if (wr && in[11:7] != 5'd0) m_x[in[11:7]] = wv;
    m_pc = npc;
  endtask

  task automatic hold_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  // Stores x0..x31 to 0x100.. so every register value appears on the ports.
  task automatic add_dump(input int idx, output int end_addr);
    for (int i = 0; i < 32; i++) imem[idx + i] = enc_s(12'(256 + 4 * i), 5'(i), 5'd0, 3'd2);
    end_addr = (idx + 32) * 4;
  endtask

  task automatic run_prog(input int end_addr);
    exp_t e;
    int   n;
    #2;
    chk("rst_instr_addr", instr_addr, 32'h0);
    chk("rst_write", {31'd0, should_write_mem}, 32'd0);
    chk("rst_read", {31'd0, should_read_mem}, 32'd0);
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    @(posedge clk); #1 reset = 1'b1;
    n = 0;
    while (m_pc != end_addr && n < 400) begin
      model_step(e);
      exp_q.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    chk("prog_complete", m_pc, end_addr);
  endtask

  task automatic gen_random(input int nins, output int end_addr);
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] bad [6];
    logic [2:0]  bf3 [6];
    int          k;
    bad[0] = 32'h0000000F; bad[1] = 32'h00000073; bad[2] = 32'h00100073;
    bad[3] = 32'h30529073; bad[4] = enc_i(12'd4, 5'd0, 3'd0, 5'd7, O_LD);
    bad[5] = enc_s(12'd4, 5'd5, 5'd0, 3'd0);
    bf3[0] = 3'd0; bf3[1] = 3'd1; bf3[2] = 3'd4; bf3[3] = 3'd5; bf3[4] = 3'd6; bf3[5] = 3'd7;
    clear_imem();
    for (int i = 0; i < nins; i++) begin
      rd = 5'($urandom_range(0, 31)); r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7)); imm = 12'($urandom());
      k  = $urandom_range(1, (nins - i) < 4 ? (nins - i) : 4);
      case ($urandom_range(0, 11))
        0, 1, 2, 3: begin
          if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
          if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
          imem[i] = enc_i(imm, r1, f3, rd, O_OPI);
        end
        4, 5: imem[i] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                              r2, r1, f3, rd);
        6:  imem[i] = {20'($urandom()), rd, ($urandom_range(0, 1) == 1) ? O_LUI : O_AUI};
        7:  imem[i] = enc_i(12'(4 * $urandom_range(0, 63)), 5'd0, 3'd2, rd, O_LD);
        8:  imem[i] = enc_s(12'(4 * $urandom_range(0, 63)), r2, 5'd0, 3'd2);
        9:  imem[i] = enc_b(13'(4 * k), r2, r1, bf3[$urandom_range(0, 5)]);
        10: imem[i] = enc_j(21'(4 * k), rd);
        default: imem[i] = bad[$urandom_range(0, 5)];
      endcase
    end
    add_dump(nins, end_addr);
  endtask

  initial begin
    int ea;
    // addi t0,x0,1 ; addi t1,t0,2
    hold_reset(); clear_imem();
    imem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd5, O_OPI);
    imem[1] = enc_i(12'd2, 5'd5, 3'd0, 5'd6, O_OPI);
    add_dump(2, ea); run_prog(ea);
    chk("p1_x5", dmem[64 + 5], 32'd1);
    chk("p1_x6", dmem[64 + 6], 32'd3);

    // reset asserted while a SW is being presented
    hold_reset(); clear_imem();
    imem[0] = enc_i(12'h066, 5'd0, 3'd0, 5'd5, O_OPI);
    imem[1] = enc_s(12'd12, 5'd5, 5'd0, 3'd2);
    imem[2] = enc_i(12'd9, 5'd0, 3'd0, 5'd7, O_OPI);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #3;
    chk("sw_write_hi", {31'd0, should_write_mem}, 32'd1);
    chk("sw_addr", data_addr, 32'd12);
    chk("sw_wdata", mem_write_data, 32'h66);
    reset = 1'b0; #1;
    chk("midrst_write_lo", {31'd0, should_write_mem}, 32'd0);
    chk("midrst_pc", instr_addr, 32'h0);
    @(posedge clk); #1;
    chk("midrst_no_store", dmem[3], m_mem[3]);
    clear_imem(); add_dump(0, ea); run_prog(ea);
    chk("midrst_x5_zero", dmem[64 + 5], 32'd0);

    // addi t0,x0,0x55 ; sw t0,8(x0) ; lw t1,8(x0)
    hold_reset(); clear_imem();
    imem[0] = enc_i(12'h055, 5'd0, 3'd0, 5'd5, O_OPI);
    imem[1] = enc_s(12'd8, 5'd5, 5'd0, 3'd2);
    imem[2] = enc_i(12'd8, 5'd0, 3'd2, 5'd6, O_LD);
    add_dump(3, ea); run_prog(ea);
    chk("p2_mem8", dmem[2], 32'h55);
    chk("p2_x6", dmem[64 + 6], 32'h55);

    // bltu taken over one instruction, then blt not taken
    hold_reset(); clear_imem();
    imem[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, O_OPI);
    imem[1] = enc_b(13'd8, 5'd5, 5'd0, 3'd6);
    imem[2] = enc_i(12'd1, 5'd0, 3'd0, 5'd7, O_OPI);
    imem[3] = enc_i(12'd2, 5'd0, 3'd0, 5'd8, O_OPI);
    imem[4] = enc_b(13'd8, 5'd5, 5'd0, 3'd4);
    imem[5] = enc_i(12'd3, 5'd0, 3'd0, 5'd9, O_OPI);
    imem[6] = enc_i(12'd4, 5'd0, 3'd0, 5'd10, O_OPI);
    add_dump(7, ea); run_prog(ea);
    chk("p3_skipped", dmem[64 + 7], 32'd0);
    chk("p3_x8", dmem[64 + 8], 32'd2);
    chk("p3_not_taken", dmem[64 + 9], 32'd3);
    chk("p3_x10", dmem[64 + 10], 32'd4);

    // jal ra,+12 at PC=4 ; jalr x0,0(ra) returns to 8
    hold_reset(); clear_imem();
    imem[0] = enc_i(12'd0, 5'd0, 3'd0, 5'd0, O_OPI);
    imem[1] = enc_j(21'd12, 5'd1);
    imem[2] = enc_i(12'd7, 5'd0, 3'd0, 5'd11, O_OPI);
    imem[3] = enc_j(21'd12, 5'd0);
    imem[4] = enc_i(12'd0, 5'd1, 3'd0, 5'd0, O_JALR);
    add_dump(6, ea); run_prog(ea);
    chk("p4_ra", dmem[64 + 1], 32'd8);
    chk("p4_x11", dmem[64 + 11], 32'd7);

    // lui t0,0x12345 ; addi x0,x0,5 ; sub t1,x0,t0
    hold_reset(); clear_imem();
    imem[0] = {20'h12345, 5'd5, O_LUI};
    imem[1] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, O_OPI);
    imem[2] = enc_r(7'h20, 5'd5, 5'd0, 3'd0, 5'd6);
    add_dump(3, ea); run_prog(ea);
    chk("p5_x5", dmem[64 + 5], 32'h12345000);
    chk("p5_x0", dmem[64 + 0], 32'd0);
    chk("p5_x6", dmem[64 + 6], 32'hEDCBB000);

    for (int p = 0; p < 8; p++) begin
      hold_reset();
      gen_random(48, ea);
      run_prog(ea);
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
